// File: rtl/pwl_pkg.sv
// ============================================================================
// pwl_pkg : symmetry modes, fold tag layout and saturating arithmetic helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package pwl_pkg;

    localparam int PWL_M = 4;
    localparam int PWL_N = 8;
    localparam int PWL_W = PWL_M + PWL_N;

    typedef enum logic [1:0] {
        SYM_NONE = 2'd0,
        SYM_ODD  = 2'd1,
        SYM_EVEN = 2'd2,
        SYM_COMP = 2'd3
    } sym_mode_e;

    // Per-beat side information that travels alongside the PWL latency.
    typedef struct packed {
        logic      valid;
        logic      neg;
        sym_mode_e mode;
`ifdef PWL_SAT_CNT_EN
        logic      fsat;
`endif
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi)
            sat_clamp = hi;
        else if (v < lo)
            sat_clamp = lo;
        else
            sat_clamp = v;
    endfunction

    function automatic logic in_range(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        in_range = (v <= hi) && (v >= -hi - 32'sd1);
    endfunction

    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
        sat_neg = sat_clamp(-v, w);
    endfunction

    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        sat_sub = sat_clamp(a - b, w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwl_sync_fifo.sv
// ============================================================================
// pwl_sync_fifo : first-word-fall-through synchronous FIFO with occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module pwl_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           rd_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           valid_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_rd;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        next_ptr = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_rd   = rd_i && (count_q != '0);
        wptr_d  = wr_i  ? next_ptr(wptr_q) : wptr_q;
        rptr_d  = do_rd ? next_ptr(rptr_q) : rptr_q;
        count_d = count_q + CW'(wr_i) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_i)
            mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_i && !rd_i && (count_q == DEPTH_C)));

endmodule

`default_nettype wire

// File: rtl/pwl_sym_fold.sv
// ============================================================================
// pwl_sym_fold : symmetry fold/unfold wrapper with credit flow control around
//                a fixed-latency PWL evaluator. Option macro: PWL_SAT_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module pwl_sym_fold
    import pwl_pkg::*;
#(
    parameter int M          = PWL_M,
    parameter int N          = PWL_N,
    parameter int PWL_LAT    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int COMP_CONST = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [M+N-1:0]   in_x,
    output logic signed [M+N-1:0]   pwl_x,
    input  logic signed [M+N-1:0]   pwl_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [M+N-1:0]   out_y,
    output logic                    busy
`ifdef PWL_SAT_CNT_EN
    ,
    output logic [15:0]             sat_cnt
`endif
);

    localparam int W  = M + N;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    sym_mode_e          mode_in;
    logic               accept;
    logic               fold_neg;
    logic signed [W-1:0] fold_x;
    logic signed [W-1:0] pwl_x_q;
    tag_t               tag_d;
    tag_t               tag_q [PWL_LAT+1];
    tag_t               tag_out;
    logic signed [W-1:0] unfold_y;
    logic               fifo_wr;
    logic               fifo_rd;
    logic               fifo_valid;
    logic [W-1:0]       fifo_rdata;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW:0]        credit_used;

    assign mode_in = sym_mode_e'(mode);

    always_comb begin
        fold_neg   = (mode_in != SYM_NONE) && in_x[W-1];
        fold_x     = fold_neg ? W'(sat_neg(32'(in_x), W)) : in_x;
        tag_d      = '0;
        tag_d.valid = accept;
        tag_d.neg  = fold_neg;
        tag_d.mode = mode_in;
`ifdef PWL_SAT_CNT_EN
        tag_d.fsat = fold_neg && !in_range(-32'(in_x), W);
`endif
    end

    // Tag stage k lines up with pwl_y k cycles after pwl_x was loaded;
    // the extra stage covers the register in front of the evaluator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwl_x_q    <= '0;
            inflight_q <= '0;
            for (int i = 0; i <= PWL_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            if (accept)
                pwl_x_q <= fold_x;
            tag_q[0] <= tag_d;
            for (int i = 1; i <= PWL_LAT; i++)
                tag_q[i] <= tag_q[i-1];
            inflight_q <= inflight_d;
        end
    end

    assign tag_out = tag_q[PWL_LAT];

    always_comb begin
        unfold_y = pwl_y;
        if (tag_out.neg) begin
            case (tag_out.mode)
                SYM_ODD:  unfold_y = W'(sat_neg(32'(pwl_y), W));
                SYM_COMP: unfold_y = W'(sat_sub(32'(COMP_CONST), 32'(pwl_y), W));
                default:  unfold_y = pwl_y;
            endcase
        end
    end

    assign fifo_wr     = tag_out.valid;
    assign inflight_d  = inflight_q + CW'(accept) - CW'(fifo_wr);
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign in_ready    = rst_n && (credit_used < DEPTH_C);
    assign accept      = in_valid && in_ready;
    assign fifo_rd     = out_valid && out_ready;

    pwl_sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (fifo_wr),
        .wdata_i (unfold_y),
        .rd_i    (fifo_rd),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign pwl_x     = pwl_x_q;
    assign out_valid = rst_n && fifo_valid;
    assign out_y     = rst_n ? fifo_rdata : '0;
    assign busy      = rst_n && ((inflight_q != '0) || (fifo_count != '0));

`ifdef PWL_SAT_CNT_EN
    logic        unfold_sat;
    logic [15:0] sat_cnt_q;

    always_comb begin
        unfold_sat = 1'b0;
        if (tag_out.neg && tag_out.mode == SYM_ODD)
            unfold_sat = !in_range(-32'(pwl_y), W);
        else if (tag_out.neg && tag_out.mode == SYM_COMP)
            unfold_sat = !in_range(32'(COMP_CONST) - 32'(pwl_y), W);
    end

    // One increment per beat even when both fold and unfold clip; sticks at max.
    always_ff @(posedge clk) begin
        if (!rst_n)
            sat_cnt_q <= '0;
        else if (fifo_wr && (tag_out.fsat || unfold_sat) && sat_cnt_q != 16'hFFFF)
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwl_sym_fold.sv
// ============================================================================
// tb_pwl_sym_fold : self-checking bench with a delayed-function PWL stub
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pwl_sym_fold;

    localparam int W          = 12;
    localparam int PWL_LAT    = 5;
    localparam int FIFO_DEPTH = 8;
    localparam int COMP_CONST = 256;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          mode;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_x;
    logic signed [W-1:0] pwl_x;
    logic signed [W-1:0] pwl_y;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_y;
    logic                busy;
`ifdef PWL_SAT_CNT_EN
    logic [15:0]         sat_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int out_log[$];
    int pop_cnt = 0;

    always #5 clk = ~clk;

    pwl_sym_fold #(
        .M(4), .N(8), .PWL_LAT(PWL_LAT), .FIFO_DEPTH(FIFO_DEPTH), .COMP_CONST(COMP_CONST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .pwl_x     (pwl_x),
        .pwl_y     (pwl_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
`ifdef PWL_SAT_CNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    function automatic int g(input int x);
        int v;
        case (x)
            384:     v = 243;
            512:     v = 200;
            256:     v = 100;
            -256:    v = 100;
            2047:    v = -2048;
            default: begin
                v = (x ^ 'h5A5) & 'hFFF;
                if (v >= 2048) v -= 4096;
            end
        endcase
        return v;
    endfunction

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // f(x) from the symmetry rules, evaluating g only on the folded argument
    function automatic int ref_out(input int md, input int x);
        int y;
        if (md == 0) return g(x);
        if (x >= 0) return g(x);
        y = g(clamp(-x));
        case (md)
            1:       return clamp(-y);
            2:       return y;
            default: return clamp(COMP_CONST - y);
        endcase
    endfunction

    // PWL evaluator stand-in: y = g(x) appearing PWL_LAT cycles after x
    logic signed [W-1:0] stub_q [PWL_LAT];
    always @(posedge clk) begin
        stub_q[0] <= W'(g(int'(pwl_x)));
        for (int i = 1; i < PWL_LAT; i++)
            stub_q[i] <= stub_q[i-1];
    end
    assign pwl_y = stub_q[PWL_LAT-1];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("sb_unexpected_output", 1, 0);
                else
                    check("sb_data", int'(out_y), exp_q.pop_front());
                out_log.push_back(int'(out_y));
                pop_cnt++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_out(int'(mode), int'(in_x)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc, input string nm);
        int c;
        c = 0;
        while ((busy || out_valid) && c < max_cyc) begin
            tick();
            c++;
        end
        check({nm, "_drain_busy"}, int'(busy), 0);
    endtask

    typedef struct {
        logic [1:0] md;
        int         x;
        int         exp_px;
        int         exp_y;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int k);
        string s;
        s = $sformatf("vec%0d", k);
        in_valid = 1'b1;
        mode     = v.md;
        in_x     = W'(v.x);
        check({s, "_in_ready"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check({s, "_pwl_x"}, int'(pwl_x), v.exp_px);
        repeat (PWL_LAT) tick();
        check({s, "_early_valid"}, int'(out_valid), 0);
        tick();
        check({s, "_valid"}, int'(out_valid), 1);
        check({s, "_out_y"}, int'(out_y), v.exp_y);
        tick();
        check({s, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic drive_random_beat();
        int r;
        int x;
        r = $urandom_range(0, 7);
        case (r)
            0:       x = -2048;
            1:       x = 2047;
            2:       x = 0;
            default: x = int'($urandom_range(0, 4095)) - 2048;
        endcase
        mode = 2'($urandom_range(0, 3));
        in_x = W'(x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic acc;
        int p0;
        int exp_il[4];

        vecs[0] = '{2'd1, -384,  384,  -243};
        vecs[1] = '{2'd3, -512,  512,  56};
        vecs[2] = '{2'd3,  512,  512,  200};
        vecs[3] = '{2'd1, -2048, 2047, 2047};
        vecs[4] = '{2'd2, -256,  256,  100};
        vecs[5] = '{2'd0, -256, -256,  100};
        exp_il  = '{100, -100, 100, 156};

        // Reset held with a beat offered
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'd1;
        in_x      = W'(-384);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_busy", int'(busy), 0);
        end
        check("rst_pwl_x", int'(pwl_x), 0);
        check("rst_out_y", int'(out_y), 0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        wait_idle(40, "rst");

        // Directed single beats with exact latency
        for (int k = 0; k < 6; k++)
            run_vec(vecs[k], k);

        // Backpressure: stalled sink, 20 offered beats
        out_ready = 1'b0;
        idx = 0;
        p0 = pop_cnt;
        for (int c = 0; c < 30; c++) begin
            in_valid = (idx < 20);
            mode     = 2'(idx % 4);
            in_x     = W'(idx * 97 - 1000);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        check("bp_accepted", idx, FIFO_DEPTH);
        check("bp_in_ready_low", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 300 && idx < 20; c++) begin
            in_valid = 1'b1;
            mode     = 2'(idx % 4);
            in_x     = W'(idx * 97 - 1000);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", idx, 20);
        wait_idle(60, "bp");
        check("bp_all_out", pop_cnt - p0, 20);

        // Mode interleave on a fixed sample
        out_log.delete();
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1;
            mode     = 2'(m);
            in_x     = W'(-256);
            tick();
        end
        in_valid = 1'b0;
        wait_idle(40, "il");
        check("il_count", out_log.size(), 4);
        for (int m = 0; m < 4 && m < out_log.size(); m++)
            check($sformatf("il_out%0d", m), out_log[m], exp_il[m]);

        // Randomised traffic against the reference model
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive_random_beat();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle(100, "rand");
        check("rand_leftover", exp_q.size(), 0);

        // Reset in the middle of traffic drops everything
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive_random_beat();
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mr_busy", int'(busy), 0);
        check("mr_out_valid", int'(out_valid), 0);
        check("mr_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        repeat (12) tick();
        check("mr_busy_later", int'(busy), 0);
        check("mr_out_valid_later", int'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
